// File: rtl/link_pkg.sv
// link_pkg: shared types and sizing for the chunked 4-phase datagram link (rx and future tx).
package link_pkg;
    localparam int MSG_W_DEF   = 96;
    localparam int CHUNK_W_DEF = 6;

    typedef enum logic [1:0] {WAIT_LOW, IDLE, CAPTURE, ACK} link_rx_state_t;

    function automatic int nchunk(input int msg_w, input int chunk_w);
        return (msg_w + chunk_w - 1) / chunk_w;
    endfunction
endpackage

// File: rtl/bit_synchronizer.sv
// bit_synchronizer: multi-flop synchroniser for a single asynchronous level.
module bit_synchronizer #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);
    logic [STAGES-1:0] r_sync;

    always_ff @(posedge clk)
        r_sync <= rst ? {STAGES{RST_VAL}} : {r_sync[STAGES-2:0], i_d};

    assign o_q = r_sync[STAGES-1];
endmodule

// File: rtl/datagram_link_rx.sv
// datagram_link_rx: 4-phase chunk receiver, reassembles a datagram and commits it
// from a shadow register immediately or on frame_sync so the consumer never sees a torn frame.
module datagram_link_rx
    import link_pkg::*;
#(
    parameter int MSG_W           = MSG_W_DEF,
    parameter int CHUNK_W         = CHUNK_W_DEF,
    parameter int SYNC_STAGES     = 2,
    parameter bit COMMIT_ON_FRAME = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_link_req,
    input  logic               i_link_sof,
    input  logic [CHUNK_W-1:0] i_link_data,
    output logic               o_link_ack,
    input  logic               i_frame_sync,
    output logic [MSG_W-1:0]   o_datagram,
    output logic               o_datagram_valid,
    output logic               o_update_pulse,
    output logic [7:0]         o_err_count,
    output logic [7:0]         o_ovr_count
);
    localparam int NCHUNK = nchunk(MSG_W, CHUNK_W);
    localparam int IW     = NCHUNK > 1 ? $clog2(NCHUNK) : 1;
    localparam int AW     = NCHUNK * CHUNK_W;
    localparam logic [IW-1:0] LAST = IW'(NCHUNK - 1);

    logic w_req_s;

    // Resetting the synchroniser high makes a req held across reset look asserted,
    // so WAIT_LOW only leaves once the sender has genuinely dropped it.
    bit_synchronizer #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_req_sync (
        .clk (clk),
        .rst (rst),
        .i_d (i_link_req),
        .o_q (w_req_s)
    );

    link_rx_state_t   r_state;
    logic             r_ack;
    logic [IW-1:0]    r_idx;
    logic [AW-1:0]    r_asm;
    logic [MSG_W-1:0] r_shadow;
    logic [MSG_W-1:0] r_datagram;
    logic             r_pending;
    logic             r_valid;
    logic             r_update;
    logic [7:0]       r_err;
    logic [7:0]       r_ovr;

    logic          w_cap;
    logic [IW-1:0] w_pos;
    logic [AW-1:0] w_asm;
    logic          w_accept;
    logic          w_bad;
    logic          w_done;
    logic          w_commit;

    // sof always restarts at chunk 0 with a clean word, whatever index we were at.
    always_comb begin
        w_cap    = r_state == CAPTURE;
        w_pos    = i_link_sof ? '0 : r_idx;
        w_asm    = i_link_sof ? '0 : r_asm;
        w_asm[w_pos*CHUNK_W +: CHUNK_W] = i_link_data;
        w_accept = w_cap && (i_link_sof || r_idx != '0);
        w_bad    = w_cap && (i_link_sof ? r_idx != '0 : r_idx == '0);
        w_done   = w_accept && w_pos == LAST;
        w_commit = r_pending && (!COMMIT_ON_FRAME || i_frame_sync);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= WAIT_LOW;
            r_ack      <= 1'b0;
            r_idx      <= '0;
            r_asm      <= '0;
            r_shadow   <= '0;
            r_datagram <= '0;
            r_pending  <= 1'b0;
            r_valid    <= 1'b0;
            r_update   <= 1'b0;
            r_err      <= '0;
            r_ovr      <= '0;
        end else begin
            r_update <= w_commit;
            if (w_commit) begin
                r_datagram <= r_shadow;
                r_valid    <= 1'b1;
            end
            // A commit in the completion cycle takes the old shadow; the new word stays pending.
            if (w_done) begin
                r_shadow  <= w_asm[MSG_W-1:0];
                r_pending <= 1'b1;
            end else if (w_commit) begin
                r_pending <= 1'b0;
            end
            if (w_done && r_pending && !w_commit && r_ovr != 8'hFF)
                r_ovr <= r_ovr + 8'd1;
            if (w_bad && r_err != 8'hFF)
                r_err <= r_err + 8'd1;
            if (w_accept) begin
                r_asm <= w_asm;
                r_idx <= w_done ? '0 : w_pos + IW'(1);
            end
            case (r_state)
                WAIT_LOW: if (!w_req_s) r_state <= IDLE;
                IDLE:     if (w_req_s) r_state <= CAPTURE;
                CAPTURE: begin
                    r_state <= ACK;
                    r_ack   <= 1'b1;
                end
                ACK: if (!w_req_s) begin
                    r_state <= IDLE;
                    r_ack   <= 1'b0;
                end
                default: r_state <= WAIT_LOW;
            endcase
        end
    end

    assign o_link_ack       = r_ack;
    assign o_datagram       = r_datagram;
    assign o_datagram_valid = r_valid;
    assign o_update_pulse   = r_update;
    assign o_err_count      = r_err;
    assign o_ovr_count      = r_ovr;
endmodule

// File: tb/tb_datagram_link_rx.sv
// tb_datagram_link_rx: randomized 4-phase sender against a message-level model,
// driving a frame-committed and an immediate-commit receiver in parallel.
module tb_datagram_link_rx;
    localparam int MW = 12;
    localparam int CW = 6;
    localparam int NC = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req = 1'b0;
    logic          sof = 1'b0;
    logic [CW-1:0] data = '0;
    logic          fs = 1'b0;
    logic          ack, dv, up, ack_i, dv_i, up_i;
    logic [MW-1:0] dg, dg_i;
    logic [7:0]    err, ovr, err_i, ovr_i;

    int n_chk = 0;
    int n_bad = 0;

    int            m_q[$];
    logic [MW-1:0] m_shadow, m_dg, m_last;
    bit            m_pend, m_valid, m_any;
    int            m_err, m_ovr;

    always #5 clk = ~clk;

    datagram_link_rx #(.MSG_W(MW), .CHUNK_W(CW), .SYNC_STAGES(2), .COMMIT_ON_FRAME(1'b1)) u_dut (
        .clk(clk), .rst(rst), .i_link_req(req), .i_link_sof(sof), .i_link_data(data),
        .o_link_ack(ack), .i_frame_sync(fs), .o_datagram(dg), .o_datagram_valid(dv),
        .o_update_pulse(up), .o_err_count(err), .o_ovr_count(ovr)
    );

    datagram_link_rx #(.MSG_W(MW), .CHUNK_W(CW), .SYNC_STAGES(2), .COMMIT_ON_FRAME(1'b0)) u_dut_imm (
        .clk(clk), .rst(rst), .i_link_req(req), .i_link_sof(sof), .i_link_data(data),
        .o_link_ack(ack_i), .i_frame_sync(fs), .o_datagram(dg_i), .o_datagram_valid(dv_i),
        .o_update_pulse(up_i), .o_err_count(err_i), .o_ovr_count(ovr_i)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic m_reset();
        m_q.delete();
        m_shadow = '0; m_dg = '0; m_last = '0;
        m_pend = 0; m_valid = 0; m_any = 0;
        m_err = 0; m_ovr = 0;
    endtask

    // Message-level view: a queue of received chunks, packed LS chunk first on completion.
    task automatic m_apply(input bit s, input int d, input bit f, output bit done);
        longint w = 0;
        done = 0;
        if (s) begin
            if (m_q.size() != 0 && m_err < 255) m_err++;
            m_q.delete();
            m_q.push_back(d);
        end else if (m_q.size() == 0) begin
            if (m_err < 255) m_err++;
        end else begin
            m_q.push_back(d);
        end
        if (f && m_pend) begin
            m_dg = m_shadow; m_valid = 1; m_pend = 0;
        end
        if (m_q.size() == NC) begin
            foreach (m_q[k]) w = w + (longint'(m_q[k]) << (CW * k));
            m_q.delete();
            done = 1;
            m_last = MW'(w);
            m_any = 1;
            if (m_pend && m_ovr < 255) m_ovr++;
            m_shadow = MW'(w);
            m_pend = 1;
        end
    endtask

    task automatic send(input bit s, input logic [CW-1:0] d, input bit f_same);
        int n = 0;
        bit done;
        @(posedge clk); #1;
        sof = s; data = d; req = 1'b1;
        while (n < 20) begin
            @(posedge clk); n++; #1;
            fs = f_same && n == 3;
            if (ack) break;
        end
        fs = 1'b0;
        chk("ack_latency", n, 4);
        m_apply(s, int'(d), f_same, done);
        if (done) begin
            @(posedge clk); #1;
            chk("imm_dg", dg_i, m_last);
            chk("imm_pulse", up_i, 1);
        end
        req = 1'b0;
        n = 0;
        while (ack && n < 20) begin
            @(posedge clk); n++; #1;
        end
        chk("ack_fall", ack, 0);
        repeat (2) @(posedge clk);
    endtask

    task automatic send_msg(input logic [MW-1:0] w, input bit f_on_last);
        send(1'b1, w[CW-1:0], 1'b0);
        send(1'b0, w[MW-1:CW], f_on_last);
    endtask

    task automatic pulse_fs();
        bit exp;
        @(posedge clk); #1;
        fs = 1'b1;
        exp = m_pend;
        @(posedge clk); #1;
        fs = 1'b0;
        if (m_pend) begin
            m_dg = m_shadow; m_valid = 1; m_pend = 0;
        end
        chk("update_pulse", up, exp);
        @(posedge clk); #1;
        chk("update_clear", up, 0);
    endtask

    task automatic check_state();
        #1;
        chk("datagram", dg, m_dg);
        chk("valid", dv, m_valid);
        chk("err_count", err, m_err);
        chk("ovr_count", ovr, m_ovr);
        chk("imm_datagram", dg_i, m_last);
        chk("imm_valid", dv_i, m_any);
        chk("imm_err", err_i, m_err);
        chk("imm_ovr", ovr_i, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired after %0d vectors", n_chk);
        $fatal(1);
    end

    initial begin
        int n;
        bit done, s, f;
        m_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack", ack, 0);
        chk("rst_up", up, 0);
        check_state();
        rst = 1'b0;
        repeat (6) @(posedge clk);

        send(1'b1, 6'h15, 1'b0);
        send(1'b0, 6'h2A, 1'b0);
        pulse_fs();
        chk("t1_dg", dg, 12'hA95);
        chk("t1_valid", dv, 1);
        check_state();

        send(1'b1, 6'h01, 1'b0);
        send(1'b1, 6'h3F, 1'b0);
        send(1'b0, 6'h00, 1'b0);
        pulse_fs();
        chk("t2_err", err, 1);
        chk("t2_dg", dg, 12'h03F);
        check_state();

        send_msg(12'h111, 1'b0);
        send_msg(12'h222, 1'b0);
        pulse_fs();
        chk("t3_ovr", ovr, 1);
        chk("t3_dg", dg, 12'h222);
        check_state();

        send_msg(12'h111, 1'b0);
        send_msg(12'h333, 1'b1);
        chk("t4_dg_old", dg, 12'h111);
        chk("t4_ovr", ovr, 1);
        pulse_fs();
        chk("t4_dg_new", dg, 12'h333);
        check_state();

        send_msg(12'h5A5, 1'b0);
        chk("t6_imm_dg", dg_i, 12'h5A5);
        pulse_fs();
        check_state();

        send(1'b1, 6'h07, 1'b0);
        @(posedge clk); #1;
        sof = 1'b1; data = 6'h09; req = 1'b1;
        n = 0;
        while (!ack && n < 20) begin
            @(posedge clk); n++; #1;
        end
        chk("t5_ack_up", ack, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("t5_ack_drop", ack, 0);
        m_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("t5_ack_hold", ack, 0);
        check_state();
        req = 1'b0;
        repeat (6) @(posedge clk);
        send_msg(12'h6C3, 1'b0);
        pulse_fs();
        chk("t5_dg", dg, 12'h6C3);
        check_state();

        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 9) < 2) begin
                pulse_fs();
            end else begin
                s = ($urandom_range(0, 7) != 0) ? (m_q.size() == 0) : 1'($urandom_range(0, 1));
                f = $urandom_range(0, 3) == 0;
                send(s, 6'($urandom_range(0, 63)), f);
            end
            check_state();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
        $finish;
    end
endmodule
